// File: rtl/fecha_editor_pkg.sv
// Shared types and constants for the date-entry stage: FSM states,
// field codes, BCD calendar limits and a state-to-field decode helper.
package fecha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EDIT_DIA  = 3'd1,
    ST_EDIT_MES  = 3'd2,
    ST_EDIT_YEAR = 3'd3,
    ST_COMMIT    = 3'd4,
    ST_HOLDOFF   = 3'd5
  } state_e;

  localparam logic [1:0] FIELD_DIA  = 2'd0;
  localparam logic [1:0] FIELD_MES  = 2'd1;
  localparam logic [1:0] FIELD_YEAR = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_99 = 8'h99;
  localparam logic [7:0] BCD_28 = 8'h28;
  localparam logic [7:0] BCD_29 = 8'h29;
  localparam logic [7:0] BCD_30 = 8'h30;
  localparam logic [7:0] BCD_31 = 8'h31;

  // Which field a given state is editing (NONE outside the edit states).
  function automatic logic [1:0] field_of(input state_e st);
    logic [1:0] f;
    case (st)
      ST_EDIT_DIA:  f = FIELD_DIA;
      ST_EDIT_MES:  f = FIELD_MES;
      ST_EDIT_YEAR: f = FIELD_YEAR;
      default:      f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fecha_editor_if.sv
// Button inputs and committed/display outputs of the date editor.
// master = button/display side, slave = the editor itself.
interface fecha_editor_if;
  logic       btn_edit;
  logic       btn_up;
  logic       btn_down;
  logic       btn_next;
  logic       btn_ok;
  logic       btn_cancel;
  logic [7:0] dia;
  logic [7:0] mes;
  logic [7:0] year;
  logic       chs;
  logic       busy;
  logic       editing;
  logic [1:0] field;
  logic [7:0] edit_val;

  modport master (
    output btn_edit, btn_up, btn_down, btn_next, btn_ok, btn_cancel,
    input  dia, mes, year, chs, busy, editing, field, edit_val
  );

  modport slave (
    input  btn_edit, btn_up, btn_down, btn_next, btn_ok, btn_cancel,
    output dia, mes, year, chs, busy, editing, field, edit_val
  );
endinterface

// File: rtl/fecha_editor_bcd_step.sv
// Combinational BCD increment/decrement of one field with wrap between
// min_i and max_i. Simultaneous up and down leave the value unchanged.
module bcd_step (
  input  logic [7:0] value_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  output logic [7:0] value_o
);

  // Digit-wise BCD +/-1; the wrap compares are valid because BCD orders like binary.
  always_comb begin
    value_o = value_i;
    if (up_i && !down_i) begin
      if (value_i >= max_i) begin
        value_o = min_i;
      end else if (value_i[3:0] == 4'd9) begin
        value_o = {value_i[7:4] + 4'd1, 4'd0};
      end else begin
        value_o = {value_i[7:4], value_i[3:0] + 4'd1};
      end
    end else if (down_i && !up_i) begin
      if (value_i <= min_i) begin
        value_o = max_i;
      end else if (value_i[3:0] == 4'd0) begin
        value_o = {value_i[7:4] - 4'd1, 4'd9};
      end else begin
        value_o = {value_i[7:4], value_i[3:0] - 4'd1};
      end
    end else begin
      value_o = value_i;
    end
  end

endmodule

// File: rtl/fecha_editor.sv
// Date-entry stage: committed BCD day/month/year plus an editable shadow
// copy, button edge detection, calendar limits and a commit strobe with
// holdoff so the downstream RTC writer sees stable values.
module fecha_editor
  import fecha_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 170,
  parameter logic [7:0]  RST_DIA        = 8'h01,
  parameter logic [7:0]  RST_MES        = 8'h01,
  parameter logic [7:0]  RST_YEAR       = 8'h16
) (
  input logic        clock,
  input logic        reset,
  fecha_editor_if.slave bus
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

  // Leap rule on BCD digits: tens even -> units 0/4/8, tens odd -> units 2/6.
  function automatic logic is_leap(input logic [7:0] y);
    logic leap;
    if (y[4] == 1'b0) begin
      leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    end else begin
      leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    end
    return leap;
  endfunction

  // Last valid BCD day of month m in year y.
  function automatic logic [7:0] month_len(input logic [7:0] m, input logic [7:0] y);
    logic [7:0] len;
    case (m)
      8'h02:                      len = is_leap(y) ? BCD_29 : BCD_28;
      8'h04, 8'h06, 8'h09, 8'h11: len = BCD_30;
      default:                    len = BCD_31;
    endcase
    return len;
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  btn_q;
  logic [5:0]  btn_s;
  logic [5:0]  pulse_s;
  logic [7:0]  dia_q, mes_q, year_q, dia_d, mes_d, year_d;
  logic [7:0]  s_dia_q, s_mes_q, s_year_q, s_dia_d, s_mes_d, s_year_d;
  logic [15:0] cnt_q, cnt_d;
  logic        chs_q, busy_q, editing_q;
  logic [1:0]  field_q;
  logic [7:0]  edit_val_q;

  logic [1:0]  field_cur_s, field_nxt_s;
  logic [7:0]  sel_val_s, sel_min_s, sel_max_s, step_val_s, edit_val_s;
  logic        step_up_s, step_dn_s;
  logic [7:0]  mes_len_s, year_len_s;

  // Bit order: 0 edit, 1 up, 2 down, 3 next, 4 ok, 5 cancel.
  assign btn_s   = {bus.btn_cancel, bus.btn_ok, bus.btn_next,
                    bus.btn_down, bus.btn_up, bus.btn_edit};
  assign pulse_s = btn_s & ~btn_q;

  // Opposing up/down pulses cancel each other.
  assign step_up_s = pulse_s[1] & ~pulse_s[2];
  assign step_dn_s = pulse_s[2] & ~pulse_s[1];

  assign field_cur_s = field_of(state_q);
  assign field_nxt_s = field_of(state_d);

  // Select the shadow field and its wrap limits for the shared stepper.
  always_comb begin
    sel_val_s = BCD_00;
    sel_min_s = BCD_00;
    sel_max_s = BCD_99;
    case (field_cur_s)
      FIELD_DIA: begin
        sel_val_s = s_dia_q;
        sel_min_s = BCD_01;
        sel_max_s = month_len(s_mes_q, s_year_q);
      end
      FIELD_MES: begin
        sel_val_s = s_mes_q;
        sel_min_s = BCD_01;
        sel_max_s = BCD_12;
      end
      FIELD_YEAR: begin
        sel_val_s = s_year_q;
        sel_min_s = BCD_00;
        sel_max_s = BCD_99;
      end
      default: begin
        sel_val_s = BCD_00;
        sel_min_s = BCD_00;
        sel_max_s = BCD_99;
      end
    endcase
  end

  bcd_step u_step (
    .value_i (sel_val_s),
    .up_i    (step_up_s),
    .down_i  (step_dn_s),
    .min_i   (sel_min_s),
    .max_i   (sel_max_s),
    .value_o (step_val_s)
  );

  // Day limits after a month or year step, used for the same-cycle clamp.
  assign mes_len_s  = month_len(step_val_s, s_year_q);
  assign year_len_s = month_len(s_mes_q, step_val_s);

  // Next state, shadow edits, commit and holdoff countdown.
  // Committed values load on the ok edge so they change together with chs rising.
  always_comb begin
    state_d  = state_q;
    dia_d    = dia_q;
    mes_d    = mes_q;
    year_d   = year_q;
    s_dia_d  = s_dia_q;
    s_mes_d  = s_mes_q;
    s_year_d = s_year_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        s_dia_d  = dia_q;
        s_mes_d  = mes_q;
        s_year_d = year_q;
        if (pulse_s[0]) begin
          state_d = ST_EDIT_DIA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT_DIA, ST_EDIT_MES, ST_EDIT_YEAR: begin
        if (pulse_s[5]) begin
          state_d  = ST_IDLE;
          s_dia_d  = dia_q;
          s_mes_d  = mes_q;
          s_year_d = year_q;
        end else if (pulse_s[4]) begin
          state_d = ST_COMMIT;
          dia_d   = s_dia_q;
          mes_d   = s_mes_q;
          year_d  = s_year_q;
        end else if (pulse_s[3]) begin
          case (state_q)
            ST_EDIT_DIA: state_d = ST_EDIT_MES;
            ST_EDIT_MES: state_d = ST_EDIT_YEAR;
            default:     state_d = ST_EDIT_DIA;
          endcase
        end else if (step_up_s || step_dn_s) begin
          case (field_cur_s)
            FIELD_DIA: begin
              s_dia_d = step_val_s;
            end
            FIELD_MES: begin
              s_mes_d = step_val_s;
              if (s_dia_q > mes_len_s) begin
                s_dia_d = mes_len_s;
              end else begin
                s_dia_d = s_dia_q;
              end
            end
            FIELD_YEAR: begin
              s_year_d = step_val_s;
              if (s_dia_q > year_len_s) begin
                s_dia_d = year_len_s;
              end else begin
                s_dia_d = s_dia_q;
              end
            end
            default: begin
              s_dia_d = s_dia_q;
            end
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_COMMIT: begin
        state_d = ST_HOLDOFF;
        cnt_d   = HOLD_LOAD;
      end
      ST_HOLDOFF: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Display value of the field selected after this edge.
  always_comb begin
    case (field_nxt_s)
      FIELD_DIA:  edit_val_s = s_dia_d;
      FIELD_MES:  edit_val_s = s_mes_d;
      FIELD_YEAR: edit_val_s = s_year_d;
      default:    edit_val_s = BCD_00;
    endcase
  end

  // State, data and registered output flops; button samples track inputs always.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      btn_q      <= 6'b000000;
      dia_q      <= RST_DIA;
      mes_q      <= RST_MES;
      year_q     <= RST_YEAR;
      s_dia_q    <= RST_DIA;
      s_mes_q    <= RST_MES;
      s_year_q   <= RST_YEAR;
      cnt_q      <= 16'd0;
      chs_q      <= 1'b0;
      busy_q     <= 1'b0;
      editing_q  <= 1'b0;
      field_q    <= FIELD_NONE;
      edit_val_q <= BCD_00;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_s;
      dia_q      <= dia_d;
      mes_q      <= mes_d;
      year_q     <= year_d;
      s_dia_q    <= s_dia_d;
      s_mes_q    <= s_mes_d;
      s_year_q   <= s_year_d;
      cnt_q      <= cnt_d;
      chs_q      <= (state_d == ST_COMMIT);
      busy_q     <= (state_d == ST_COMMIT) || (state_d == ST_HOLDOFF);
      editing_q  <= (field_nxt_s != FIELD_NONE);
      field_q    <= field_nxt_s;
      edit_val_q <= edit_val_s;
    end
  end

  assign bus.dia      = dia_q;
  assign bus.mes      = mes_q;
  assign bus.year     = year_q;
  assign bus.chs      = chs_q;
  assign bus.busy     = busy_q;
  assign bus.editing  = editing_q;
  assign bus.field    = field_q;
  assign bus.edit_val = edit_val_q;

endmodule

// File: tb/tb_fecha_editor.sv
// Bench for fecha_editor: decimal calendar model checked every cycle,
// directed scenarios with literal expectations, then random button traffic.
module tb_fecha_editor;
  localparam int HOLD = 170;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] btns  = 6'b000000; // 0 edit,1 up,2 down,3 next,4 ok,5 cancel
  int checks = 0;
  int errors = 0;

  fecha_editor_if bif();
  assign bif.btn_edit   = btns[0];
  assign bif.btn_up     = btns[1];
  assign bif.btn_down   = btns[2];
  assign bif.btn_next   = btns[3];
  assign bif.btn_ok     = btns[4];
  assign bif.btn_cancel = btns[5];

  fecha_editor #(
    .HOLDOFF_CYCLES(HOLD), .RST_DIA(8'h01), .RST_MES(8'h01), .RST_YEAR(8'h16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clock = ~clock;

  // Model state in plain decimal integers.
  int m_mode = 0;      // 0 idle, 1 editing, 2 busy after commit
  int m_sel = 0;       // 0 day, 1 month, 2 year
  int m_sd = 1, m_sm = 1, m_sy = 16;
  int m_cd = 1, m_cm = 1, m_cy = 16;
  int m_busy_left = 0; // busy cycles still to show, HOLD+1 right after ok
  logic [5:0] m_prev = 6'b000000;

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    else if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    else return 31;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [5:0] p;
    int mx;
    p = btns & ~m_prev;
    m_prev = btns;
    if (reset) begin
      m_prev = 6'b000000; m_mode = 0; m_sel = 0; m_busy_left = 0;
      m_cd = 1; m_cm = 1; m_cy = 16; m_sd = 1; m_sm = 1; m_sy = 16;
      return;
    end
    if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
      if (m_busy_left == 0) m_mode = 0;
    end else if (m_mode == 0) begin
      m_sd = m_cd; m_sm = m_cm; m_sy = m_cy;
      if (p[0]) begin m_mode = 1; m_sel = 0; end
    end else begin
      if (p[5]) begin
        m_mode = 0; m_sd = m_cd; m_sm = m_cm; m_sy = m_cy;
      end else if (p[4]) begin
        m_cd = m_sd; m_cm = m_sm; m_cy = m_sy;
        m_mode = 2; m_busy_left = HOLD + 1;
      end else if (p[3]) begin
        m_sel = (m_sel + 1) % 3;
      end else if (p[1] ^ p[2]) begin
        mx = dim(m_sm, m_sy);
        if (m_sel == 0) m_sd = p[1] ? ((m_sd == mx) ? 1 : m_sd + 1) : ((m_sd == 1) ? mx : m_sd - 1);
        else if (m_sel == 1) m_sm = p[1] ? (m_sm % 12 + 1) : ((m_sm == 1) ? 12 : m_sm - 1);
        else m_sy = p[1] ? ((m_sy + 1) % 100) : ((m_sy + 99) % 100);
        if (m_sd > dim(m_sm, m_sy)) m_sd = dim(m_sm, m_sy);
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    int sv;
    @(negedge clock);
    sv = (m_sel == 0) ? m_sd : (m_sel == 1) ? m_sm : m_sy;
    chk("dia", bif.dia, bcd(m_cd));
    chk("mes", bif.mes, bcd(m_cm));
    chk("year", bif.year, bcd(m_cy));
    chk("chs", bif.chs, (m_busy_left == HOLD + 1));
    chk("busy", bif.busy, (m_busy_left > 0));
    chk("editing", bif.editing, (m_mode == 1));
    chk("field", bif.field, (m_mode == 1) ? m_sel : 3);
    chk("edit_val", bif.edit_val, (m_mode == 1) ? bcd(sv) : 8'h00);
  end

  task automatic press(input int b);
    @(negedge clock);
    btns[b] = 1'b1;
    @(negedge clock);
    btns[b] = 1'b0;
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bif.busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clock);
    end
    chk("busy_timeout", bif.busy, 1'b0);
  endtask

  initial begin
    int n;
    int nchs;
    repeat (3) @(negedge clock);
    chk("rst_dia", bif.dia, 8'h01);
    chk("rst_mes", bif.mes, 8'h01);
    chk("rst_year", bif.year, 8'h16);
    chk("rst_field", bif.field, 2'd3);
    chk("rst_busy", bif.busy, 1'b0);
    reset = 1'b0;

    // edit, next, up x3, ok -> month 04 committed
    press(0); press(3); press_n(1, 3);
    chk("mes_edit4", bif.edit_val, 8'h04);
    press(4);
    chk("commit_chs", bif.chs, 1'b1);
    chk("commit_mes", bif.mes, 8'h04);
    chk("commit_dia", bif.dia, 8'h01);
    chk("model_mes", m_cm, 4);
    wait_busy(n);
    chk("busy_len", n, 171);
    chk("idle_field", bif.field, 2'd3);

    // wrap boundaries, then cancel
    press(0); press(2);
    chk("day_wrap_down", bif.edit_val, 8'h30);
    press(3); press_n(2, 3);
    chk("mes_01", bif.edit_val, 8'h01);
    press(2);
    chk("mes_wrap_down", bif.edit_val, 8'h12);
    press(1); press(3); press_n(2, 17);
    chk("year_99", bif.edit_val, 8'h99);
    press(1);
    chk("year_wrap_up", bif.edit_val, 8'h00);
    press(5);
    chk("cancel_edit", bif.editing, 1'b0);
    chk("cancel_mes", bif.mes, 8'h04);
    chk("cancel_year", bif.year, 8'h16);
    chk("cancel_chs", bif.chs, 1'b0);

    // clamp: day 31 in Jan, then Feb 16 -> 29, then year 17 -> 28
    press(0); press(3); press_n(2, 3); press(3); press(3); press(2);
    chk("day_31", bif.edit_val, 8'h31);
    press(3); press(1);
    chk("mes_02", bif.edit_val, 8'h02);
    press(3); press(3);
    chk("clamp_29", bif.edit_val, 8'h29);
    chk("model_clamp_29", m_sd, 29);
    press(3); press(3); press(1);
    chk("year_17", bif.edit_val, 8'h17);
    press(3);
    chk("clamp_28", bif.edit_val, 8'h28);
    press(4);
    chk("commit2_dia", bif.dia, 8'h28);
    chk("commit2_mes", bif.mes, 8'h02);
    chk("commit2_year", bif.year, 8'h17);
    wait_busy(n);

    // ok pulsed again during holdoff -> single chs
    press(0); press(4);
    nchs = 0;
    for (int i = 0; i < 250; i++) begin
      if (bif.chs === 1'b1) nchs++;
      if (i == 5) btns[4] = 1'b1;
      if (i == 6) btns[4] = 1'b0;
      @(negedge clock);
    end
    chk("single_chs", nchs, 1);

    // up and down together -> no change
    press(0);
    @(negedge clock);
    btns[1] = 1'b1; btns[2] = 1'b1;
    @(negedge clock);
    btns[1] = 1'b0; btns[2] = 1'b0;
    chk("updown_same", bif.edit_val, 8'h28);
    press(5);

    // reset during holdoff
    press(0); press(4);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rsth_busy", bif.busy, 1'b0);
    chk("rsth_dia", bif.dia, 8'h01);
    chk("rsth_mes", bif.mes, 8'h01);
    chk("rsth_year", bif.year, 8'h16);
    reset = 1'b0;

    // random button traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      btns[0] = ($urandom_range(0, 99) < 8);
      btns[1] = ($urandom_range(0, 99) < 30);
      btns[2] = ($urandom_range(0, 99) < 30);
      btns[3] = ($urandom_range(0, 99) < 12);
      btns[4] = ($urandom_range(0, 99) < 3);
      btns[5] = ($urandom_range(0, 99) < 3);
      reset   = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clock);
    btns = 6'b000000;
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fecha_editor.md
# fecha_editor

Upstream date-entry stage for the RTC date writer. Holds committed BCD day/month/year, lets the user edit a shadow copy with up/down/next/ok/cancel buttons, applies calendar limits (month length, leap year), and on commit issues a one-cycle `chs` strobe to the downstream writer. The committed values are frozen until the writer has finished its bus sequence.

## Interface
- `HOLDOFF_CYCLES`, 170: cycles `busy` stays high after `chs`. Must be at least the writer's 161-cycle sequence.
- `RST_DIA`, 8'h01: BCD reset day.
- `RST_MES`, 8'h01: BCD reset month.
- `RST_YEAR`, 8'h16: BCD reset year.
- `clock` in 1: system clock. All logic on posedge.
- `reset` in 1: synchronous, active-high.
- `btn_edit` in 1: level, debounced. Rising edge enters edit.
- `btn_up` in 1: level, debounced. Rising edge increments the selected field.
- `btn_down` in 1: level, debounced. Rising edge decrements the selected field.
- `btn_next` in 1: level, debounced. Rising edge selects the next field.
- `btn_ok` in 1: level, debounced. Rising edge commits.
- `btn_cancel` in 1: level, debounced. Rising edge discards edits.
- `dia` out 8: committed day, BCD 01–31.
- `mes` out 8: committed month, BCD 01–12.
- `year` out 8: committed year, BCD 00–99.
- `chs` out 1: one-cycle commit strobe to the writer.
- `busy` out 1: high from `chs` through holdoff.
- `editing` out 1: high in any EDIT state.
- `field` out 2: 0 = day, 1 = month, 2 = year, 3 = none.
- `edit_val` out 8: shadow value of the selected field, for display. 8'h00 when `field` = 3.

## Operation
- Registers: committed `dia`/`mes`/`year`; shadow `s_dia`/`s_mes`/`s_year`; previous-sample flop per button; FSM; holdoff counter.
- Edge pulse = button high and its previous sample low. Only pulses act; held levels never repeat.
- Pulse priority in one cycle: cancel > ok > next > up/down. If up and down pulse together, both are ignored.
- FSM states: IDLE, EDIT_DIA, EDIT_MES, EDIT_YEAR, COMMIT, HOLDOFF.
- IDLE:
  - edit pulse → EDIT_DIA.
  - On entry, shadow is loaded from committed.
- EDIT_* states:
  - next pulse cycles DIA→MES→YEAR→DIA.
  - cancel pulse → IDLE. Shadow is reloaded from committed.
  - ok pulse → COMMIT.
  - edit pulse is ignored.
- COMMIT (exactly 1 cycle):
  - Committed values ← shadow.
  - `chs` = 1.
  - Holdoff counter ← HOLDOFF_CYCLES-1.
  - Next state is HOLDOFF.
- HOLDOFF:
  - Counter decrements each cycle. At 0 → IDLE.
  - All button pulses are ignored.
  - Committed values are held stable.
- BCD arithmetic is done on the field value, never binary-wrapped.
  - Day: up wraps max→01; down wraps 01→max.
  - Month: up wraps 12→01; down wraps 01→12.
  - Year: up wraps 99→00; down wraps 00→99.
- Month length:
  - 02 → 29 if leap, else 28.
  - 04/06/09/11 → 30.
  - All other months → 31.
- Leap year: (tens even and units ∈ {0,4,8}) or (tens odd and units ∈ {2,6}). 00 counts as leap.
- Clamp: whenever `s_mes` or `s_year` changes and `s_dia` exceeds the new max, `s_dia` ← max in the same cycle.

## Timing
- Reset values:
  - `dia`/`mes`/`year` = RST_*; shadow equals committed.
  - State IDLE; button flops 0.
  - `chs` = 0, `busy` = 0, `editing` = 0, `field` = 3, `edit_val` = 8'h00.
- Button latency: a level first sampled high at edge k updates state/shadow at edge k. The effect is visible after edge k.
- `chs` is high during the cycle after the ok edge, for exactly 1 cycle.
- `dia`/`mes`/`year` update on the same edge that raises `chs`.
- `busy` rises with `chs` and stays high for HOLDOFF_CYCLES+1 cycles total, including the COMMIT cycle.
- A button held high through HOLDOFF does not generate a pulse at exit. Its previous-sample flop tracks the input continuously.
- Reset mid-edit or mid-holdoff: everything returns to reset values and `chs` stays 0. The shadow is lost.

## Structure
- Shared package `fecha_pkg`:
  - State enum.
  - Field codes FIELD_DIA/FIELD_MES/FIELD_YEAR/FIELD_NONE.
  - BCD limit constants 8'h01, 8'h12, 8'h99, 8'h28, 8'h29, 8'h30, 8'h31.
- Sub-module `bcd_step`: combinational BCD ±1 with parameterless min/max wrap inputs.
  - Inputs: value[7:0], up, down, min[7:0], max[7:0].
  - Output: value next.
  - Instantiated once, muxed by `field`.
- The month-length/leap function lives in `fecha_editor`.

## Test plan
- Reset → `dia`/`mes`/`year` = 01/01/16, `chs` = 0, `busy` = 0, `field` = 3.
- edit, next, up ×3, ok → `chs` pulse 1 cycle, `mes` = 8'h04, `dia` = 8'h01, `busy` high 171 cycles, then IDLE.
- Edit day to 31 in month 01, then set month to 02 with year 16 → `s_dia` clamps to 8'h29.
  - Change year to 17 → `s_dia` clamps to 8'h28.
- Day down from 01 with month 04 → 8'h30.
  - Year up from 99 → 00.
  - Month down from 01 → 12.
- Edit and change values, then pulse cancel → IDLE, committed unchanged, no `chs`.
  - ok pulsed during HOLDOFF → ignored, single `chs` only.
- up and down high in the same cycle → no change.
  - Reset asserted in HOLDOFF → IDLE, `busy` = 0, values at RST_*.
